// File: rtl/lc3_pkg.sv
// Shared types and helpers for the multi-cycle LC-3 core.
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_IND,
        S_MEM,
        S_HALT
    } state_e;

    localparam logic [7:0] TRAP_HALT = 8'h25;

    // Sign-extend the low w bits of v; the upper bits of v are ignored.
    function automatic logic [15:0] sext(input logic [15:0] v, input int unsigned w);
        logic signed [15:0] t;
        t = $signed(v << (16 - w));
        return t >>> (16 - w);
    endfunction

    function automatic logic [2:0] cc_of(input logic [15:0] r);
        return {r[15], r == 16'h0000, !r[15] && (r != 16'h0000)};
    endfunction

endpackage

// File: rtl/lc3_regfile.sv
// Eight 16-bit general registers: two combinational read ports, one write port.
module lc3_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  ra_addr,
    input  logic [2:0]  rb_addr,
    output logic [15:0] ra_data,
    output logic [15:0] rb_data,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata
);
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/lc3_mc_core.sv
// Multi-cycle LC-3 core (no RTI) with a req/ready memory port, TRAP, indirect modes and HALT.
module lc3_mc_core import lc3_pkg::*; #(
    parameter logic [15:0] RESET_PC     = 16'h3000,
    parameter int          ADDR_W       = 16,
    parameter bit          HALT_ON_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [15:0]       pc,
    output logic [2:0]        cc
);
    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d, ir_q, ir_d, ea_q, ea_d;
    logic [2:0]  cc_q, cc_d;

    opcode_e     op;
    logic        is_store, access, accept, br_taken;
    logic [15:0] ra_data, rb_data, op2, pc_rel9, addr16, alu_res;
    logic [2:0]  rb_addr;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;

    assign op       = opcode_e'(ir_q[15:12]);
    assign is_store = (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    assign access   = (state_q == S_FETCH) || (state_q == S_IND) || (state_q == S_MEM);
    assign accept   = access && mem_ready;
    assign rb_addr  = is_store ? ir_q[11:9] : ir_q[2:0];
    assign op2      = ir_q[5] ? sext(ir_q, 5) : rb_data;
    assign pc_rel9  = pc_q + sext(ir_q, 9);
    assign br_taken = |(ir_q[11:9] & cc_q);
    assign addr16   = (state_q == S_FETCH) ? pc_q : ea_q;

    lc3_regfile u_rf (
        .clk     (clk),
        .rst_n   (reset),
        .ra_addr (ir_q[8:6]),
        .rb_addr (rb_addr),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ea_q    <= '0;
            cc_q    <= 3'b010;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ea_q    <= ea_d;
            cc_q    <= cc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (accept) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_LD, OP_LDR, OP_ST, OP_STR: state_d = S_MEM;
                    OP_LDI, OP_STI:               state_d = S_IND;
                    OP_TRAP: state_d = (HALT_ON_TRAP && ir_q[7:0] == TRAP_HALT) ? S_HALT : S_IND;
                    OP_RTI, OP_RES:               state_d = S_HALT;
                    default:                      state_d = S_FETCH;
                endcase
            end
            S_IND:    if (accept) state_d = (op == OP_TRAP) ? S_FETCH : S_MEM;
            S_MEM:    if (accept) state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        case (op)
            OP_ADD:  alu_res = ra_data + op2;
            OP_AND:  alu_res = ra_data & op2;
            default: alu_res = ~ra_data;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        ea_d     = ea_q;
        cc_d     = cc_q;
        rf_we    = 1'b0;
        rf_waddr = ir_q[11:9];
        rf_wdata = alu_res;
        case (state_q)
            S_FETCH:  if (accept) ir_d = mem_rdata;
            S_DECODE: pc_d = pc_q + 16'd1;
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        rf_we = 1'b1;
                        cc_d  = cc_of(alu_res);
                    end
                    OP_BR:  if (br_taken) pc_d = pc_rel9;
                    OP_JMP: pc_d = ra_data;
                    // Target comes from the read port before R7 is overwritten at this edge.
                    OP_JSR: begin
                        rf_we    = 1'b1;
                        rf_waddr = 3'd7;
                        rf_wdata = pc_q;
                        pc_d     = ir_q[11] ? pc_q + sext(ir_q, 11) : ra_data;
                    end
                    OP_LEA: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_rel9;
                    end
                    OP_LD, OP_ST, OP_LDI, OP_STI: ea_d = pc_rel9;
                    OP_LDR, OP_STR:               ea_d = ra_data + sext(ir_q, 6);
                    OP_TRAP:                      ea_d = {8'h00, ir_q[7:0]};
                    default: ;
                endcase
            end
            S_IND: begin
                if (accept) begin
                    if (op == OP_TRAP) begin
                        rf_we    = 1'b1;
                        rf_waddr = 3'd7;
                        rf_wdata = pc_q;
                        pc_d     = mem_rdata;
                    end else begin
                        ea_d = mem_rdata;
                    end
                end
            end
            S_MEM: begin
                if (accept && !is_store) begin
                    rf_we    = 1'b1;
                    rf_wdata = mem_rdata;
                    cc_d     = cc_of(mem_rdata);
                end
            end
            default: ;
        endcase
    end

    // Bus outputs are gated by reset so an in-flight request vanishes the moment reset asserts.
    always_comb begin
        mem_req   = reset && access;
        mem_we    = mem_req && (state_q == S_MEM) && is_store;
        mem_addr  = mem_req ? addr16[ADDR_W-1:0] : '0;
        mem_wdata = mem_we ? rb_data : '0;
        halted    = (state_q == S_HALT);
        pc        = pc_q;
        cc        = cc_q;
    end

endmodule

// File: tb/tb_lc3_mc_core.sv
// Scoreboarded bench for lc3_mc_core: expected bus transactions queued, checked on acceptance.
module tb_lc3_mc_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, halted;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        mem_ready = 1'b1;
    logic [2:0]  cc;

    logic [15:0] mem [0:65535];

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] stall_addr = 16'hFFFF;
    int          stall_left = 0;
    int          stall_seen = 0;
    int          n;
    int          req_seen;

    lc3_mc_core #(
        .RESET_PC     (16'h3000),
        .ADDR_W       (16),
        .HALT_ON_TRAP (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .pc        (pc),
        .cc        (cc)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder and monitor: ready for the coming edge is chosen here, then the
    // transaction that edge will accept is compared against the head of the queue.
    always @(negedge clk) begin
        if (mem_req && mem_addr == stall_addr) stall_seen++;
        if (mem_req && mem_addr == stall_addr && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = 1'b1;
        end
        if (mem_req && mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL txn_unexpected: got we=%b addr=%h expected no transaction", mem_we, mem_addr);
            end else begin
                cur = exp_q.pop_front();
                check("txn_we", 32'(mem_we), 32'(cur.we));
                check("txn_addr", 32'(mem_addr), 32'(cur.addr));
                if (cur.we) check("txn_wdata", 32'(mem_wdata), 32'(cur.data));
            end
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end

    task automatic ex(input logic we, input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back('{we: we, addr: a, data: d});
    endtask

    task automatic fetch(input logic [15:0] a);
        ex(1'b0, a, 16'h0000);
    endtask

    task automatic restart();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_pc", 32'(pc), 32'h3000);
        #1 reset = 1'b1;
        #1;
        check("first_req", 32'(mem_req), 32'd1);
        check("first_we", 32'(mem_we), 32'd0);
        check("first_addr", 32'(mem_addr), 32'h3000);
        check("first_cc", 32'(cc), 32'b010);
        check("first_halted", 32'(halted), 32'd0);
    endtask

    task automatic wait_fetch(input logic [15:0] a, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!(mem_req && !mem_we && mem_addr == a) && cyc < budget);
        check("reach_fetch", 32'(mem_req && mem_addr == a), 32'd1);
    endtask

    task automatic wait_halt(input int budget);
        int c;
        c = 0;
        while (!halted && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("halted", 32'(halted), 32'd1);
        check("txn_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // ALU, stores, branches, TRAP x25 halt
        mem[16'h3000] = 16'h5260; mem[16'h3001] = 16'h1265; mem[16'h3002] = 16'h147A;
        mem[16'h3003] = 16'h340C; mem[16'h3004] = 16'h9ABF; mem[16'h3005] = 16'h7A7F;
        mem[16'h3006] = 16'h0401; mem[16'h3007] = 16'hD000; mem[16'h3008] = 16'h0001;
        mem[16'h3009] = 16'hF025;
        fetch(16'h3000); fetch(16'h3001); fetch(16'h3002); fetch(16'h3003);
        ex(1'b1, 16'h3010, 16'hFFFF);
        fetch(16'h3004); fetch(16'h3005);
        ex(1'b1, 16'h0004, 16'h0000);
        fetch(16'h3006); fetch(16'h3008); fetch(16'h3009);
        restart();
        wait_fetch(16'h3001, 20, n);
        check("alu_latency", 32'(n), 32'd4);
        check("pc_after_and", 32'(pc), 32'h3001);
        wait_fetch(16'h3003, 20, n);
        check("cc_after_add", 32'(cc), 32'b100);
        wait_halt(80);
        check("a_pc", 32'(pc), 32'h300A);
        check("a_cc", 32'(cc), 32'b010);
        req_seen = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (mem_req) req_seen++;
        end
        check("halt_idle_req", 32'(req_seen), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);

        // LD with three wait states on the data read
        mem[16'h3000] = 16'h2802; mem[16'h3001] = 16'h3805; mem[16'h3002] = 16'hF025;
        mem[16'h3003] = 16'hA5A5;
        fetch(16'h3000);
        ex(1'b0, 16'h3003, 16'h0000);
        fetch(16'h3001);
        ex(1'b1, 16'h3007, 16'hA5A5);
        fetch(16'h3002);
        stall_addr = 16'h3003;
        stall_left = 3;
        stall_seen = 0;
        restart();
        wait_fetch(16'h3001, 30, n);
        check("ld_wait_latency", 32'(n), 32'd8);
        wait_halt(40);
        check("ld_addr_stable", 32'(stall_seen), 32'd4);
        check("b_cc", 32'(cc), 32'b100);
        check("b_pc", 32'(pc), 32'h3003);
        stall_addr = 16'hFFFF;

        // LDI through a pointer, BRn, store of the loaded value
        mem[16'h3000] = 16'hA604; mem[16'h3001] = 16'h0801; mem[16'h3002] = 16'hD000;
        mem[16'h3003] = 16'h360A; mem[16'h3004] = 16'hF025; mem[16'h3005] = 16'h4000;
        mem[16'h4000] = 16'h8000;
        fetch(16'h3000);
        ex(1'b0, 16'h3005, 16'h0000);
        ex(1'b0, 16'h4000, 16'h0000);
        fetch(16'h3001); fetch(16'h3003);
        ex(1'b1, 16'h300E, 16'h8000);
        fetch(16'h3004);
        restart();
        wait_halt(60);
        check("c_cc", 32'(cc), 32'b100);
        check("c_pc", 32'(pc), 32'h3005);

        // JSRR R7, TRAP through the vector table, JMP R7, reserved opcode halt
        mem[16'h3000] = 16'h2E03; mem[16'h3001] = 16'h41C0; mem[16'h3004] = 16'h3100;
        mem[16'h3100] = 16'h3E04; mem[16'h3101] = 16'hF030; mem[16'h3102] = 16'hD000;
        mem[16'h0030] = 16'h3200; mem[16'h3200] = 16'h3E01; mem[16'h3201] = 16'hC1C0;
        fetch(16'h3000);
        ex(1'b0, 16'h3004, 16'h0000);
        fetch(16'h3001); fetch(16'h3100);
        ex(1'b1, 16'h3105, 16'h3002);
        fetch(16'h3101);
        ex(1'b0, 16'h0030, 16'h0000);
        fetch(16'h3200);
        ex(1'b1, 16'h3202, 16'h3102);
        fetch(16'h3201); fetch(16'h3102);
        restart();
        wait_halt(80);
        check("d_pc", 32'(pc), 32'h3103);
        check("d_cc", 32'(cc), 32'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
